// File: rtl/if_fetch_unit_if.sv
// Bundle of the fetch stage's ROM port, ID-stage interface and redirect inputs.
// The master side is the fetch unit. The slave side is its environment:
// the ID stage, the exception unit and the instruction ROM.
interface if_fetch_unit_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              branch_flag;
  logic [ADDR_W-1:0] branch_addr;
  logic              id_stall;
  logic              flush;
  logic [ADDR_W-1:0] flush_pc;
  logic              rom_req;
  logic [ADDR_W-1:0] rom_addr;
  logic              rom_ack;
  logic [31:0]       rom_rdata;
  logic              id_valid;
  logic [ADDR_W-1:0] id_pc;
  logic [31:0]       id_inst;

  modport master (
    input  branch_flag, branch_addr, id_stall, flush, flush_pc, rom_ack, rom_rdata,
    output rom_req, rom_addr, id_valid, id_pc, id_inst
  );

  modport slave (
    output branch_flag, branch_addr, id_stall, flush, flush_pc, rom_ack, rom_rdata,
    input  rom_req, rom_addr, id_valid, id_pc, id_inst
  );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage of the 5-stage MIPS pipeline.
// Owns the PC, fetches over a req/ack ROM port and presents {pc, inst, valid}
// to ID. A taken branch lets the in-flight delay-slot word through and then
// redirects. If no fetch is in flight when the branch is taken, the target is
// parked in a pending register. A word that arrives while ID is stalled is
// parked in a one-entry skid register. A flush that lands on an outstanding
// request waits for that request to finish (DRAIN) and discards its data.
module if_fetch_unit #(
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(32'hBFC0_0000)
) (
  input  logic           clk,
  input  logic           rst,
  if_fetch_unit_if.master bus
);

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(32'd4);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              pend_valid_q, pend_valid_d;
  logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
  logic [ADDR_W-1:0] skid_pc_q, skid_pc_d;
  logic [31:0]       skid_inst_q, skid_inst_d;
  logic              id_valid_q, id_valid_d;
  logic [ADDR_W-1:0] id_pc_q, id_pc_d;
  logic [31:0]       id_inst_q, id_inst_d;
  logic              rom_req_q, rom_req_d;
  logic              consume_s;
  logic              take_s;

  assign consume_s = id_valid_q & ~bus.id_stall;
  assign take_s    = bus.branch_flag & consume_s;

  assign bus.rom_req  = rom_req_q;
  assign bus.rom_addr = pc_q;
  assign bus.id_valid = id_valid_q;
  assign bus.id_pc    = id_pc_q;
  assign bus.id_inst  = id_inst_q;

  // Next-state, PC, redirect, skid and ID-output decisions.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    pend_valid_d = pend_valid_q;
    pend_addr_d  = pend_addr_q;
    skid_pc_d    = skid_pc_q;
    skid_inst_d  = skid_inst_q;
    id_valid_d   = id_valid_q;
    id_pc_d      = id_pc_q;
    id_inst_d    = id_inst_q;

    if (bus.flush) begin
      // The flush outranks everything, including a branch taken in the same cycle.
      id_valid_d   = 1'b0;
      skid_pc_d    = '0;
      skid_inst_d  = 32'd0;
      pend_valid_d = 1'b0;
      pend_addr_d  = '0;
      if (rom_req_q && !bus.rom_ack) begin
        // The request is still open: finish it in DRAIN, then redirect.
        pend_valid_d = 1'b1;
        pend_addr_d  = bus.flush_pc;
        state_d      = ST_DRAIN;
      end else begin
        pc_d    = bus.flush_pc;
        state_d = ST_FETCH;
      end
    end else begin
      case (state_q)
        ST_BOOT: begin
          state_d = ST_FETCH;
        end
        ST_FETCH: begin
          if (bus.rom_ack) begin
            if (take_s) begin
              pc_d = bus.branch_addr;
            end else if (pend_valid_q) begin
              pc_d         = pend_addr_q;
              pend_valid_d = 1'b0;
            end else begin
              pc_d = pc_q + PC_STEP;
            end
            if (id_valid_q && bus.id_stall) begin
              skid_pc_d   = pc_q;
              skid_inst_d = bus.rom_rdata;
              state_d     = ST_HOLD;
            end else begin
              id_valid_d = 1'b1;
              id_pc_d    = pc_q;
              id_inst_d  = bus.rom_rdata;
            end
          end else begin
            if (consume_s) begin
              id_valid_d = 1'b0;
            end else begin
              id_valid_d = id_valid_q;
            end
            if (take_s) begin
              // The word still in flight is the delay slot; it stays live.
              pend_valid_d = 1'b1;
              pend_addr_d  = bus.branch_addr;
            end else begin
              pend_valid_d = pend_valid_q;
            end
          end
        end
        ST_HOLD: begin
          if (!bus.id_stall) begin
            id_valid_d = 1'b1;
            id_pc_d    = skid_pc_q;
            id_inst_d  = skid_inst_q;
            state_d    = ST_FETCH;
            if (take_s) begin
              // The skid word is the delay slot; nothing is in flight.
              pc_d = bus.branch_addr;
            end else begin
              pc_d = pc_q;
            end
          end else begin
            state_d = ST_HOLD;
          end
        end
        ST_DRAIN: begin
          if (bus.rom_ack) begin
            pc_d         = pend_addr_q;
            pend_valid_d = 1'b0;
            state_d      = ST_FETCH;
          end else begin
            state_d = ST_DRAIN;
          end
        end
        default: begin
          state_d = ST_BOOT;
        end
      endcase
    end

    rom_req_d = (state_d == ST_FETCH) || (state_d == ST_DRAIN);
  end

  // State and datapath registers; async reset abandons any open request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_BOOT;
      pc_q         <= RESET_PC;
      pend_valid_q <= 1'b0;
      pend_addr_q  <= '0;
      skid_pc_q    <= '0;
      skid_inst_q  <= 32'd0;
      id_valid_q   <= 1'b0;
      id_pc_q      <= '0;
      id_inst_q    <= 32'd0;
      rom_req_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      pend_valid_q <= pend_valid_d;
      pend_addr_q  <= pend_addr_d;
      skid_pc_q    <= skid_pc_d;
      skid_inst_q  <= skid_inst_d;
      id_valid_q   <= id_valid_d;
      id_pc_q      <= id_pc_d;
      id_inst_q    <= id_inst_d;
      rom_req_q    <= rom_req_d;
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Testbench for if_fetch_unit. A program-order reference model queues the PC
// that ID must see next. A monitor pops that queue on every consumed
// instruction and also checks request stability, stall freezing and liveness.
module tb_if_fetch_unit;
  localparam logic [31:0] RESET_PC = 32'hBFC0_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;

  if_fetch_unit_if #(.ADDR_W(32)) bus ();

  if_fetch_unit #(.ADDR_W(32), .RESET_PC(RESET_PC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: architectural instruction stream in program order.
  logic [31:0] exp_q[$];
  logic [31:0] last_pc;
  logic        redir_pending;
  logic [31:0] redir_target;

  // ROM contents are a fixed function of the address.
  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  assign bus.rom_rdata = rom_word(bus.rom_addr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: actual %h required %h", name, act, req);
    end
  endtask

  function automatic logic [31:0] gen_target();
    logic [31:0] r;
    int          sel;
    r   = $urandom();
    sel = $urandom_range(0, 7);
    if (sel == 0) return 32'hFFFF_FFF8;
    else if (sel == 1) return r;
    else return {r[31:2], 2'b00};
  endfunction

  task automatic do_reset();
    rst             = 1'b1;
    bus.id_stall    = 1'b0;
    bus.branch_flag = 1'b0;
    bus.branch_addr = 32'd0;
    bus.flush       = 1'b0;
    bus.flush_pc    = 32'd0;
    bus.rom_ack     = 1'b0;
    exp_q.delete();
    exp_q.push_back(RESET_PC);
    last_pc       = RESET_PC;
    redir_pending = 1'b0;
    redir_target  = 32'd0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // One cycle of stimulus, applied 1 time unit after a rising edge. The model
  // is updated, and the task returns 1 time unit after the next rising edge.
  task automatic cyc(input logic stall, input logic bf, input logic [31:0] ba,
                     input logic fl, input logic [31:0] fpc, input logic ack);
    logic consume;
    bus.id_stall    = stall;
    bus.branch_flag = bf;
    bus.branch_addr = ba;
    bus.flush       = fl;
    bus.flush_pc    = fpc;
    bus.rom_ack     = ack & bus.rom_req;
    consume = bus.id_valid & ~stall;
    if (fl) begin
      exp_q.delete();
      exp_q.push_back(fpc);
      last_pc       = fpc;
      redir_pending = 1'b0;
    end else if (consume) begin
      if (redir_pending) begin
        last_pc       = redir_target;
        redir_pending = 1'b0;
      end else begin
        last_pc = last_pc + 32'd4;
      end
      exp_q.push_back(last_pc);
      if (bf) begin
        redir_pending = 1'b1;
        redir_target  = ba;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: scoreboard pop on consume, plus handshake and stall invariants.
  initial begin
    logic        prev_wait, prev_hold;
    logic [31:0] prev_addr, prev_pc, prev_inst, e;
    int          idle;
    prev_wait = 1'b0; prev_hold = 1'b0;
    prev_addr = 32'd0; prev_pc = 32'd0; prev_inst = 32'd0; idle = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_wait = 1'b0;
        prev_hold = 1'b0;
        idle      = 0;
      end else begin
        if (prev_wait) begin
          check("rom_req_held", {31'd0, bus.rom_req}, 32'd1);
          check("rom_addr_held", bus.rom_addr, prev_addr);
        end
        if (prev_hold) begin
          check("id_valid_frozen", {31'd0, bus.id_valid}, 32'd1);
          check("id_pc_frozen", bus.id_pc, prev_pc);
          check("id_inst_frozen", bus.id_inst, prev_inst);
        end
        if (bus.id_valid && !bus.id_stall && !bus.flush) begin
          idle = 0;
          if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_instr: actual id_pc %h required none", bus.id_pc);
          end else begin
            e = exp_q.pop_front();
            check("id_pc", bus.id_pc, e);
            check("id_inst", bus.id_inst, rom_word(e));
          end
        end else if (bus.id_valid || bus.flush) begin
          idle = 0;
        end else begin
          idle++;
          if (idle > 100) begin
            n_checks++;
            n_errors++;
            $display("FAIL watchdog: actual %0d idle cycles required at most 100", idle);
            idle = 0;
          end
        end
        prev_wait = bus.rom_req && !bus.rom_ack;
        prev_addr = bus.rom_addr;
        prev_hold = bus.id_valid && bus.id_stall && !bus.flush;
        prev_pc   = bus.id_pc;
        prev_inst = bus.id_inst;
      end
    end
  end

  initial begin
    // Reset values, then a zero-bubble stream with ack always high.
    do_reset();
    check("rst_rom_req", {31'd0, bus.rom_req}, 32'd0);
    check("rst_id_valid", {31'd0, bus.id_valid}, 32'd0);
    check("rst_id_pc", bus.id_pc, 32'd0);
    check("rst_id_inst", bus.id_inst, 32'd0);
    cyc(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
    check("t1_addr0", bus.rom_addr, 32'hBFC0_0000);
    check("t1_req", {31'd0, bus.rom_req}, 32'd1);
    check("t1_valid_early", {31'd0, bus.id_valid}, 32'd0);
    cyc(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
    check("t1_addr1", bus.rom_addr, 32'hBFC0_0004);
    check("t1_valid", {31'd0, bus.id_valid}, 32'd1);
    check("t1_id_pc", bus.id_pc, 32'hBFC0_0000);
    cyc(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
    check("t1_addr2", bus.rom_addr, 32'hBFC0_0008);

    // Branch with single-cycle ack: the delay slot, then the target.
    do_reset();
    repeat (2) cyc(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
    cyc(1'b0, 1'b1, 32'hBFC0_0100, 1'b0, 32'd0, 1'b1);
    check("t2_dslot", bus.id_pc, 32'hBFC0_0004);
    check("t2_addr", bus.rom_addr, 32'hBFC0_0100);
    cyc(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
    check("t2_target", bus.id_pc, 32'hBFC0_0100);

    // Branch while the delay-slot ack is 3 cycles late.
    do_reset();
    repeat (2) cyc(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
    cyc(1'b0, 1'b1, 32'hBFC0_0100, 1'b0, 32'd0, 1'b0);
    repeat (2) begin
      check("t3_addr_wait", bus.rom_addr, 32'hBFC0_0004);
      cyc(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
    end
    cyc(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
    check("t3_dslot", bus.id_pc, 32'hBFC0_0004);
    check("t3_addr", bus.rom_addr, 32'hBFC0_0100);
    cyc(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
    check("t3_target", bus.id_pc, 32'hBFC0_0100);

    // Stall for 4 cycles: one word is skidded and the request stays low.
    do_reset();
    repeat (2) cyc(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
    repeat (4) begin
      cyc(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
      check("t4_frozen_pc", bus.id_pc, 32'hBFC0_0000);
      check("t4_req_low", {31'd0, bus.rom_req}, 32'd0);
      check("t4_addr", bus.rom_addr, 32'hBFC0_0008);
    end
    cyc(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
    check("t4_skid_out", bus.id_pc, 32'hBFC0_0004);
    check("t4_req_back", {31'd0, bus.rom_req}, 32'd1);
    cyc(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
    check("t4_next", bus.id_pc, 32'hBFC0_0008);

    // Flush on an open request: the word is discarded, then fetch restarts.
    do_reset();
    repeat (2) cyc(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
    cyc(1'b0, 1'b1, 32'h1234_5670, 1'b1, 32'hBFC0_0380, 1'b0);
    repeat (2) begin
      check("t5_addr_stable", bus.rom_addr, 32'hBFC0_0004);
      check("t5_valid_low", {31'd0, bus.id_valid}, 32'd0);
      cyc(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
    end
    cyc(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
    check("t5_addr_new", bus.rom_addr, 32'hBFC0_0380);
    check("t5_discard", {31'd0, bus.id_valid}, 32'd0);
    cyc(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
    check("t5_id_pc", bus.id_pc, 32'hBFC0_0380);

    // PC wraps past the top of the address space; async reset mid-wait.
    do_reset();
    repeat (2) cyc(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
    cyc(1'b0, 1'b0, 32'd0, 1'b1, 32'hFFFF_FFFC, 1'b0);
    cyc(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
    check("t6_addr_top", bus.rom_addr, 32'hFFFF_FFFC);
    cyc(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
    check("t6_wrap", bus.rom_addr, 32'h0000_0000);
    check("t6_id_pc", bus.id_pc, 32'hFFFF_FFFC);
    bus.rom_ack = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("t6_rst_req", {31'd0, bus.rom_req}, 32'd0);
    check("t6_rst_valid", {31'd0, bus.id_valid}, 32'd0);

    // Randomized traffic against the reference model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      logic        st, bf, fl, ack;
      logic [31:0] ba, fpc;
      int          ack_pct;
      case ((i / 500) % 3)
        0:       ack_pct = 100;
        1:       ack_pct = 60;
        default: ack_pct = 30;
      endcase
      st  = ($urandom_range(0, 3) == 0);
      fl  = ($urandom_range(0, 59) == 0);
      ba  = gen_target();
      fpc = gen_target();
      if (bus.id_valid && !st) bf = !redir_pending && ($urandom_range(0, 5) == 0);
      else bf = ($urandom_range(0, 3) == 0);
      ack = ($urandom_range(1, 100) <= ack_pct);
      cyc(st, bf, ba, fl, fpc, ack);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch stage of the 5-stage MIPS core, directly upstream of the ID stage.
- Owns the PC register, fetches through a req/ack instruction-ROM port, and presents {pc, inst, valid} to ID.
- Consumes ID's combinational branch_flag/branch_addr, honouring the architectural delay slot.
- Consumes pipeline stall and exception flush.

Parameters:
- RESET_PC, 32'hBFC0_0000, first fetch address after reset
- ADDR_W, 32, PC/address width; data width fixed at 32

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- branch_flag  in  1  ID-stage branch taken (combinational from ID)
- branch_addr  in  32  ID-stage branch target
- id_stall  in  1  ID cannot accept; hold outputs
- flush  in  1  exception/eret redirect pulse
- flush_pc  in  32  redirect target
- rom_req  out  1  fetch request
- rom_addr  out  32  fetch address; stable while rom_req=1
- rom_ack  in  1  response strobe; rom_rdata valid this cycle
- rom_rdata  in  32  fetched word
- id_valid  out  1  id_pc/id_inst hold a live instruction
- id_pc  out  32  PC of presented instruction
- id_inst  out  32  presented instruction

Behaviour:
- Reset (async): pc=RESET_PC, state=BOOT, rom_req=0, id_valid=0, id_pc=0, id_inst=0. Pending-target register cleared; skid register cleared.
- States: BOOT, FETCH, HOLD, DRAIN.
- BOOT: one idle cycle after reset release, then FETCH.
- rom_req=1 only in FETCH and DRAIN; rom_addr=pc.
- Once rom_req is raised, req and addr are held until rom_ack, in every state including flush.
- consume = id_valid & !id_stall.
- take = branch_flag & consume; branch_flag is ignored otherwise.
- FETCH, ack, output slot free or being consumed:
  - id_pc<=pc, id_inst<=rom_rdata, id_valid<=1.
  - Next pc, in priority order: branch_addr if take; pend_addr if pend_valid (then clear pend_valid); pc+4 otherwise.
  - pc+4 wraps mod 2^32.
  - Zero-bubble: one instruction per cycle when ack is single-cycle.
- FETCH, take with no ack this cycle: pend_valid<=1, pend_addr<=branch_addr; pc unchanged. The in-flight word is the delay slot and is kept.
- FETCH, ack while id_valid & id_stall:
  - Word and pc go to the skid register; state becomes HOLD.
  - pc advances as above.
- HOLD: rom_req=0. When id_stall drops, skid moves to the id_* outputs next cycle and state returns to FETCH.
- consume with no new word: id_valid<=0.
- Flush (highest priority, any state):
  - id_valid<=0; skid and pend cleared.
  - Request outstanding without ack this cycle: pend_addr<=flush_pc, pend_valid<=1, state DRAIN.
  - Otherwise: pc<=flush_pc, state FETCH.
- DRAIN: hold req until ack, discard rom_rdata, then pc<=pend_addr, clear pend, state FETCH.
- Flush during DRAIN overwrites pend_addr.
- Flush beats a simultaneous take.
- A take with pend_valid already set cannot legally occur; the new target overwrites.
- Misaligned targets (addr[1:0]!=0) are fetched unmodified; the AdEL check is done in the exception unit.
- Reset mid-transaction drops rom_req immediately; the ROM must tolerate an abandoned request.

Test Plan:
- Reset release, ack always 1 -> rom_addr BFC00000, BFC00004, BFC00008 on consecutive cycles; id_valid rises 2 cycles after reset release.
- Branch at id_pc=BFC00000 with branch_flag=1, addr=BFC00100, ack=1 -> next id_pcs are BFC00004 (delay slot), then BFC00100.
- Same branch, but the delay-slot ack arrives 3 cycles late -> delay slot BFC00004 is presented, then BFC00100; no wrong-path fetch.
- id_stall=1 for 4 cycles with ack=1 -> id_* frozen, exactly one word held in skid, rom_req low in HOLD; after release, in-order pcs with no loss or duplicate.
- Flush (flush_pc=BFC00380) while req outstanding and ack delayed 2 cycles -> rom_addr stable until ack, that word discarded, next rom_addr=BFC00380, id_valid=0 throughout.
- pc=FFFFFFFC, no branch -> next rom_addr=00000000; async rst asserted mid-wait -> rom_req and id_valid drop to 0 before the next clock edge.
